// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / load-store) in front of the single-port RAM.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants instead of data priority with starvation guard.
package enums_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;
endpackage

module mem_arbiter
    import enums_pkg::*;
`ifndef MEM_ARB_ROUND_ROBIN_EN
#(
    parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  mem_size_t   d_size,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] ram_address,
    output mem_size_t   ram_size,
    output logic        ram_read_enable,
    output logic        ram_write_enable,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_IF,
        RSP_D
    } rsp_t;

    rsp_t rsp_state;
    logic if_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;

    assign if_win = if_req && (!d_req || last_d);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_d <= 1'b1;
        end else if (if_gnt) begin
            last_d <= 1'b0;
        end else if (d_gnt) begin
            last_d <= 1'b1;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign if_win = if_req && (!d_req || (starve_cnt == LIMIT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // Grants are gated by reset so an access in flight is killed without waiting for a clock edge.
    assign if_gnt = if_win && !reset;
    assign d_gnt  = d_req && !if_win && !reset;

    always_comb begin
        ram_address      = '0;
        ram_size         = MEM_WORD;
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;
        ram_write_data   = '0;
        if (if_gnt) begin
            ram_address     = if_addr;
            ram_read_enable = 1'b1;
        end else if (d_gnt) begin
            ram_address      = d_addr;
            ram_size         = d_size;
            ram_read_enable  = !d_we;
            ram_write_enable = d_we;
            ram_write_data   = d_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_state <= RSP_NONE;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else if (if_gnt) begin
            rsp_state <= RSP_IF;
            if_rvalid <= 1'b1;
            d_rvalid  <= 1'b0;
            if_rdata  <= ram_read_data;
        end else if (d_gnt && !d_we) begin
            rsp_state <= RSP_D;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b1;
            d_rdata   <= ram_read_data;
        end else begin
            rsp_state <= RSP_NONE;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-masked RAM model and per-port response scoreboards.
// Contention pattern follows MEM_ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;
    import enums_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    mem_size_t   d_size;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] ram_address;
    mem_size_t   ram_size;
    logic        ram_read_enable;
    logic        ram_write_enable;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;

    mem_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_gnt           (if_gnt),
        .if_rvalid        (if_rvalid),
        .if_rdata         (if_rdata),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_addr           (d_addr),
        .d_size           (d_size),
        .d_wdata          (d_wdata),
        .d_gnt            (d_gnt),
        .d_rvalid         (d_rvalid),
        .d_rdata          (d_rdata),
        .ram_address      (ram_address),
        .ram_size         (ram_size),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable),
        .ram_write_data   (ram_write_data),
        .ram_read_data    (ram_read_data)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:63];
    assign ram_read_data = mem[ram_address[7:2]];

    always @(posedge clock) begin
        if (ram_write_enable) begin
            case (ram_size)
                MEM_BYTE: mem[ram_address[7:2]][{ram_address[1:0], 3'b000} +: 8] <= ram_write_data[7:0];
                MEM_HALF: mem[ram_address[7:2]][{ram_address[1], 4'b0000} +: 16] <= ram_write_data[15:0];
                default:  mem[ram_address[7:2]] <= ram_write_data;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_exp_t;

    rsp_exp_t if_q[$];
    rsp_exp_t d_q[$];

    // A response is due exactly one cycle after the recorded grant; any other cycle must be idle.
    always @(negedge clock) begin
        if (if_q.size() > 0 && if_q[0].cyc + 1 == cyc) begin
            chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
            chk("if_rdata", if_rdata, if_q[0].data);
            void'(if_q.pop_front());
        end else begin
            chk("if_rvalid_idle", {31'd0, if_rvalid}, 32'd0);
        end
        if (d_q.size() > 0 && d_q[0].cyc + 1 == cyc) begin
            chk("d_rvalid", {31'd0, d_rvalid}, 32'd1);
            chk("d_rdata", d_rdata, d_q[0].data);
            void'(d_q.pop_front());
        end else begin
            chk("d_rvalid_idle", {31'd0, d_rvalid}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_if(input logic [31:0] data);
        rsp_exp_t e;
        e.data = data;
        e.cyc  = cyc;
        if_q.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] data);
        rsp_exp_t e;
        e.data = data;
        e.cyc  = cyc;
        d_q.push_back(e);
    endtask

    localparam logic [31:0] W0 = 32'h0102_0304;
    localparam logic [31:0] W1 = 32'hA5A5_5A5A;
    localparam logic [31:0] W2 = 32'hCAFE_F00D;

    logic [9:0] f_pat;
    logic       f;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;
        mem[4] = 32'hDEAD_BEEF;

        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_size  = MEM_WORD;
        d_wdata = '0;

        // Reset values
        step();
        step();
        @(negedge clock);
        chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_ram_re", {31'd0, ram_read_enable}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_write_enable}, 32'd0);
        chk("rst_ram_addr", ram_address, 32'd0);
        chk("rst_ram_wdata", ram_write_data, 32'd0);
        chk("rst_ram_size", {30'd0, ram_size}, {30'd0, MEM_WORD});
        step();
        reset = 1'b0;

        // Lone fetch
        step();
        if_req  = 1'b1;
        if_addr = 32'h10;
        @(negedge clock);
        chk("f1_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("f1_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("f1_ram_addr", ram_address, 32'h10);
        chk("f1_ram_re", {31'd0, ram_read_enable}, 32'd1);
        chk("f1_ram_size", {30'd0, ram_size}, {30'd0, MEM_WORD});
        push_if(32'hDEAD_BEEF);
        step();
        if_req = 1'b0;

        // Byte store to 0x21, then word load from 0x20
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h21;
        d_size  = MEM_BYTE;
        d_wdata = 32'h0000_00AB;
        @(negedge clock);
        chk("st_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("st_ram_we", {31'd0, ram_write_enable}, 32'd1);
        chk("st_ram_re", {31'd0, ram_read_enable}, 32'd0);
        chk("st_ram_addr", ram_address, 32'h21);
        chk("st_ram_wdata", ram_write_data, 32'hAB);
        chk("st_ram_size", {30'd0, ram_size}, {30'd0, MEM_BYTE});
        step();
        d_we    = 1'b0;
        d_addr  = 32'h20;
        d_size  = MEM_WORD;
        d_wdata = '0;
        @(negedge clock);
        chk("ld_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("ld_ram_re", {31'd0, ram_read_enable}, 32'd1);
        push_d(32'h0000_AB00);
        step();
        d_req = 1'b0;
        step();

        // Contention with both requests held
`ifdef MEM_ARB_ROUND_ROBIN_EN
        f_pat = 10'b01_0101_0101;
`else
        f_pat = 10'b10_0001_0000;
`endif
        if_req  = 1'b1;
        if_addr = 32'h0;
        d_req   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            f = f_pat[i];
            @(negedge clock);
            chk($sformatf("ct%0d_if_gnt", i), {31'd0, if_gnt}, {31'd0, f});
            chk($sformatf("ct%0d_d_gnt", i), {31'd0, d_gnt}, {31'd0, !f});
            if (f) push_if(W0);
            else   push_d(32'h0000_AB00);
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();

        // Back-to-back fetches
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'(i * 4);
            @(negedge clock);
            chk($sformatf("bb%0d_if_gnt", i), {31'd0, if_gnt}, 32'd1);
            chk($sformatf("bb%0d_ram_addr", i), ram_address, 32'(i * 4));
            case (i)
                0:       push_if(W0);
                1:       push_if(W1);
                default: push_if(W2);
            endcase
            step();
        end
        if_req = 1'b0;
        step();

        // Reset asserted during a load's grant cycle
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h20;
        d_size = MEM_WORD;
        @(negedge clock);
        chk("rl_d_gnt_pre", {31'd0, d_gnt}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rl_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rl_ram_re", {31'd0, ram_read_enable}, 32'd0);
        chk("rl_ram_we", {31'd0, ram_write_enable}, 32'd0);
        chk("rl_ram_addr", ram_address, 32'd0);
        step();
        d_req = 1'b0;
        reset = 1'b0;
        step();
        step();

        // RAM contents survived the reset
        d_req = 1'b1;
        @(negedge clock);
        chk("pr_d_gnt", {31'd0, d_gnt}, 32'd1);
        push_d(32'h0000_AB00);
        step();
        d_req = 1'b0;
        step();
        step();

        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("d_q_drained", 32'(d_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port `ram` between the CPU instruction-fetch port and the load/store data port. Each cycle it grants at most one requester, drives the RAM's address/size/enable/write-data inputs from the winner, and registers the RAM's combinational read data back to that requester one cycle later. Data accesses win by default, and a starvation counter guarantees fetch forward progress.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch is waiting before fetch is forced through; legal range 1–15.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  32  fetch byte address (word access).
- `if_gnt`  out  1  fetch granted this cycle.
- `if_rvalid`  out  1  `if_rdata` valid; one-cycle pulse.
- `if_rdata`  out  32  fetched word.
- `d_req`  in  1  data request; held with all `d_*` inputs stable until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_size`  in  `enums_pkg::mem_size_t`  access size.
- `d_wdata`  in  32  store data, unaligned (RAM aligns it).
- `d_gnt`  out  1  data granted this cycle.
- `d_rvalid`  out  1  `d_rdata` valid; one-cycle pulse, loads only.
- `d_rdata`  out  32  raw aligned RAM word for the load.
- `ram_address`  out  32  to `ram.address`.
- `ram_size`  out  `mem_size_t`  to `ram.size`.
- `ram_read_enable`  out  1  to `ram.read_enable`.
- `ram_write_enable`  out  1  to `ram.write_enable`.
- `ram_write_data`  out  32  to `ram.write_data`.
- `ram_read_data`  in  32  from `ram.read_data`.

## Operation
- Grant is combinational from the `*_req` inputs and the registered arbitration state. At most one of `if_gnt`/`d_gnt` is high in any cycle.
- The RAM access occurs in the grant cycle. Reads sample `ram_read_data` at the end of that cycle. Writes commit at the same rising edge through the RAM's byte mask.
- Fetch grant drives:
  - `ram_address = if_addr`, `ram_size = MEM_WORD`
  - `ram_read_enable = 1`, `ram_write_enable = 0`, `ram_write_data = 0`
- Data grant drives:
  - `ram_address = d_addr`, `ram_size = d_size`
  - `ram_read_enable = !d_we`, `ram_write_enable = d_we`, `ram_write_data = d_wdata`
- No grant drives both enables 0, address 0, data 0 and size `MEM_WORD`.
- Default policy:
  - Data has priority.
  - `starve_cnt` (4 bit) increments on every data grant while `if_req` is high, saturating at `STARVE_LIMIT`.
  - While `starve_cnt == STARVE_LIMIT` and `if_req` is high, fetch wins over data.
  - `starve_cnt` clears on a fetch grant, or in any cycle `if_req` is low.
- Response state machine (registered):
  - States: `RSP_NONE`, `RSP_IF`, `RSP_D`.
  - The next state records the winner of the current cycle. A data store maps to `RSP_NONE`.
  - In `RSP_IF`: `if_rvalid = 1`, with `if_rdata` holding the word captured in the grant cycle.
  - In `RSP_D`: `d_rvalid = 1`, with `d_rdata` holding the captured word.
  - `*_rdata` holds its last value until the next capture for that port.
- Back-to-back grants are allowed every cycle. A response pulse and a new grant overlap freely.
- Requests withdrawn before grant are illegal. Behaviour in that case is undefined; the arbiter does not check for it.
- Reset asserted mid-access:
  - Grants and RAM enables drop immediately (asynchronous, combinationally gated by `reset`).
  - The state machine returns to `RSP_NONE`.
  - Any pending response is discarded.

## Timing
- Reset values:
  - `if_gnt = d_gnt = 0`, `if_rvalid = d_rvalid = 0`, `if_rdata = d_rdata = 0`.
  - `starve_cnt = 0`, state `RSP_NONE`.
  - `ram_read_enable = ram_write_enable = 0`, `ram_address = 0`, `ram_write_data = 0`.
- Grant latency: 0 cycles when the request wins arbitration.
- Read latency: `*_rvalid` is high in the cycle after `*_gnt`.
- Store completion: at the rising edge that ends the `d_gnt` cycle. A load of the same address granted next cycle returns the new data.
- Worst-case fetch wait under continuous data traffic: `STARVE_LIMIT` cycles.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - When both requesters are active, grants strictly alternate using a 1-bit last-winner register (reset value: data was last, so fetch wins first contention).
  - A sole requester always wins.
  - `starve_cnt` and `STARVE_LIMIT` are removed.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: data priority with starvation counter, as in Operation.

## Test plan
- Reset then lone fetch: `if_addr = 0x10`, RAM word `0xDEADBEEF` → `if_gnt` same cycle, `if_rvalid` next cycle with `if_rdata = 0xDEADBEEF`; `d_*` outputs stay 0.
- Store then load: store byte `0xAB` to `0x21`, then load word from `0x20` (word previously `0`) → `d_rvalid` with `d_rdata = 0x0000AB00`; no `d_rvalid` for the store.
- Contention, default build, `STARVE_LIMIT = 4`, `if_req` and `d_req` held high continuously → grant sequence D,D,D,D,F,D,D,D,D,F; `if_rvalid` one cycle after each F.
- Contention with `MEM_ARB_ROUND_ROBIN_EN` → grants F,D,F,D,… from the first contended cycle.
- `reset` asserted in a load's grant cycle → enables drop immediately, no `d_rvalid` afterwards, RAM contents unchanged.
- Back-to-back fetches to `0x0`, `0x4`, `0x8` → `if_rvalid` high for 3 consecutive cycles with the matching words in order.
